// File: rtl/seven_seg_if.sv
// Data and display signals between a digit source and the multiplexed
// seven-segment scanner.
interface seven_seg_if;
   logic [15:0] value_in;
   logic [3:0]  dp_in;
   logic        load;
   logic        blank_lz;
   logic [3:0]  nibble_out;
   logic [3:0]  digit_en_n;
   logic        dp_out_n;
   logic        frame_done;

   modport master (
      output value_in, dp_in, load, blank_lz,
      input  nibble_out, digit_en_n, dp_out_n, frame_done
   );

   modport slave (
      input  value_in, dp_in, load, blank_lz,
      output nibble_out, digit_en_n, dp_out_n, frame_done
   );
endinterface

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed display scanner: drive/gap slots per digit, frame-
// atomic display updates, leading-zero blanking, registered Moore outputs.
module seven_seg_scanner #(
   parameter int unsigned CLK_DIV      = 4,
   parameter int unsigned BLANK_CYCLES = 2
) (
   input logic        clk,
   input logic        rst_n,
   seven_seg_if.slave bus
);

   typedef enum logic {ST_GAP = 1'b0, ST_DRIVE = 1'b1} state_t;

   localparam logic [15:0] DRIVE_LAST = 16'(CLK_DIV - 1);
   localparam logic [15:0] GAP_LAST   = 16'(BLANK_CYCLES - 1);

   function automatic logic [3:0] digit_of(input logic [15:0] v, input logic [1:0] i);
      logic [3:0] d;
      case (i)
         2'd0:    d = v[3:0];
         2'd1:    d = v[7:4];
         2'd2:    d = v[11:8];
         2'd3:    d = v[15:12];
         default: d = 4'h0;
      endcase
      return d;
   endfunction

   // A digit is blanked when it and every more significant digit are zero.
   function automatic logic is_blanked(input logic [15:0] v, input logic [1:0] i,
                                       input logic en);
      logic b;
      case (i)
         2'd0:    b = 1'b0;
         2'd1:    b = en && (v[15:4] == 12'h000);
         2'd2:    b = en && (v[15:8] == 8'h00);
         2'd3:    b = en && (v[15:12] == 4'h0);
         default: b = 1'b0;
      endcase
      return b;
   endfunction

   state_t      state_r, state_next_s;
   logic [15:0] cnt_r, cnt_next_s;
   logic [1:0]  idx_r, idx_next_s;
   logic        boundary_s;
   logic [15:0] shadow_val_r, shadow_val_next_s;
   logic [3:0]  shadow_dp_r, shadow_dp_next_s;
   logic [15:0] disp_val_r, disp_val_next_s;
   logic [3:0]  disp_dp_r, disp_dp_next_s;
   logic        blank_s;
   logic [3:0]  nibble_r, nibble_next_s;
   logic [3:0]  digit_en_n_r, digit_en_n_next_s;
   logic        dp_out_n_r, dp_out_n_next_s;
   logic        frame_done_r;

   // Slot sequencing: next state, counter and digit index.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      idx_next_s   = idx_r;
      boundary_s   = 1'b0;
      case (state_r)
         ST_DRIVE: begin
            if (cnt_r == DRIVE_LAST) begin
               state_next_s = ST_GAP;
               cnt_next_s   = 16'd0;
            end else begin
               cnt_next_s = cnt_r + 16'd1;
            end
         end
         ST_GAP: begin
            if (cnt_r == GAP_LAST) begin
               state_next_s = ST_DRIVE;
               cnt_next_s   = 16'd0;
               idx_next_s   = idx_r + 2'd1;
               boundary_s   = (idx_r == 2'd3);
            end else begin
               cnt_next_s = cnt_r + 16'd1;
            end
         end
         default: begin
            state_next_s = ST_GAP;
            cnt_next_s   = 16'd0;
            idx_next_s   = 2'd3;
         end
      endcase
   end

   // Shadow/display update; a load on the boundary edge bypasses the shadow.
   always_comb begin
      shadow_val_next_s = shadow_val_r;
      shadow_dp_next_s  = shadow_dp_r;
      disp_val_next_s   = disp_val_r;
      disp_dp_next_s    = disp_dp_r;
      if (bus.load) begin
         shadow_val_next_s = bus.value_in;
         shadow_dp_next_s  = bus.dp_in;
      end else begin
         shadow_val_next_s = shadow_val_r;
         shadow_dp_next_s  = shadow_dp_r;
      end
      if (boundary_s) begin
         disp_val_next_s = bus.load ? bus.value_in : shadow_val_r;
         disp_dp_next_s  = bus.load ? bus.dp_in : shadow_dp_r;
      end else begin
         disp_val_next_s = disp_val_r;
         disp_dp_next_s  = disp_dp_r;
      end
   end

   // Output values for the state being entered, so the registers line up with it.
   always_comb begin
      blank_s           = is_blanked(disp_val_next_s, idx_next_s, bus.blank_lz);
      nibble_next_s     = digit_of(disp_val_next_s, idx_next_s);
      digit_en_n_next_s = 4'hF;
      dp_out_n_next_s   = 1'b1;
      if ((state_next_s == ST_DRIVE) && !blank_s) begin
         digit_en_n_next_s = ~(4'b0001 << idx_next_s);
         dp_out_n_next_s   = ~disp_dp_next_s[idx_next_s];
      end else begin
         digit_en_n_next_s = 4'hF;
         dp_out_n_next_s   = 1'b1;
      end
   end

   // State, data and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_GAP;
         cnt_r        <= 16'd0;
         idx_r        <= 2'd3;
         shadow_val_r <= 16'h0000;
         shadow_dp_r  <= 4'h0;
         disp_val_r   <= 16'h0000;
         disp_dp_r    <= 4'h0;
         nibble_r     <= 4'h0;
         digit_en_n_r <= 4'hF;
         dp_out_n_r   <= 1'b1;
         frame_done_r <= 1'b0;
      end else begin
         state_r      <= state_next_s;
         cnt_r        <= cnt_next_s;
         idx_r        <= idx_next_s;
         shadow_val_r <= shadow_val_next_s;
         shadow_dp_r  <= shadow_dp_next_s;
         disp_val_r   <= disp_val_next_s;
         disp_dp_r    <= disp_dp_next_s;
         nibble_r     <= nibble_next_s;
         digit_en_n_r <= digit_en_n_next_s;
         dp_out_n_r   <= dp_out_n_next_s;
         frame_done_r <= boundary_s;
      end
   end

   assign bus.nibble_out = nibble_r;
   assign bus.digit_en_n = digit_en_n_r;
   assign bus.dp_out_n   = dp_out_n_r;
   assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench: frame-position reference model, vector table, corner sequences.
module tb_seven_seg_scanner;
   localparam int C = 4;
   localparam int B = 2;
   localparam int F = 4 * (C + B);

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   seven_seg_if bus ();

   seven_seg_scanner #(.CLK_DIV(C), .BLANK_CYCLES(B)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference state: edges since reset release and the loaded data.
   int          m_k;
   logic [15:0] m_shadow, m_disp;
   logic [3:0]  m_sdp, m_ddp;
   logic        m_blank;

   typedef struct {
      logic [15:0] value;
      logic [3:0]  dp;
      logic        blank;
      logic [15:0] en;
      logic [15:0] nib;
      logic [3:0]  dpn;
   } vec_t;
   vec_t vecs[8];

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_k = 0; m_shadow = 16'h0; m_disp = 16'h0; m_sdp = 4'h0; m_ddp = 4'h0; m_blank = 1'b0;
   endtask

   task automatic check_model();
      int d, p;
      logic drive, blk, fd;
      logic [3:0] en, nib;
      logic dpn;
      if (m_k < B) begin
         d = 3; drive = 1'b0; fd = 1'b0;
      end else begin
         p = (m_k - B) % F;
         d = p / (C + B);
         drive = (p % (C + B)) < C;
         fd = (p == 0);
      end
      nib = m_disp[4*d +: 4];
      blk = (d > 0) && m_blank && ((m_disp >> (4 * d)) == 16'h0);
      if (drive && !blk) begin
         en  = ~(4'b0001 << d);
         dpn = ~m_ddp[d];
      end else begin
         en  = 4'hF;
         dpn = 1'b1;
      end
      chk("model_nibble", {12'h0, bus.nibble_out}, {12'h0, nib});
      chk("model_en", {12'h0, bus.digit_en_n}, {12'h0, en});
      chk("model_dp", {15'h0, bus.dp_out_n}, {15'h0, dpn});
      chk("model_frame_done", {15'h0, bus.frame_done}, {15'h0, fd});
   endtask

   task automatic step();
      @(posedge clk);
      m_k++;
      if (m_k >= B && ((m_k - B) % F) == 0) begin
         m_disp = bus.load ? bus.value_in : m_shadow;
         m_ddp  = bus.load ? bus.dp_in : m_sdp;
      end
      if (bus.load) begin
         m_shadow = bus.value_in;
         m_sdp    = bus.dp_in;
      end
      m_blank = bus.blank_lz;
      @(negedge clk);
      check_model();
   endtask

   task automatic wait_frame();
      for (int i = 0; i < F + 2; i++) begin
         step();
         if (bus.frame_done === 1'b1) break;
      end
      chk("frame_done_wait", {15'h0, bus.frame_done}, 16'h0001);
   endtask

   task automatic chk_out(input string name, input logic [3:0] en, input logic [3:0] nib,
                          input logic fd);
      chk({name, "_en"}, {12'h0, bus.digit_en_n}, {12'h0, en});
      chk({name, "_nib"}, {12'h0, bus.nibble_out}, {12'h0, nib});
      chk({name, "_fd"}, {15'h0, bus.frame_done}, {15'h0, fd});
   endtask

   initial begin
      vecs[0] = '{16'h1234, 4'h0,    1'b0, 16'h7BDE, 16'h1234, 4'hF};
      vecs[1] = '{16'h0030, 4'h0,    1'b1, 16'hFFDE, 16'h0030, 4'hF};
      vecs[2] = '{16'h0000, 4'h0,    1'b1, 16'hFFFE, 16'h0000, 4'hF};
      vecs[3] = '{16'h1234, 4'b0100, 1'b0, 16'h7BDE, 16'h1234, 4'b1011};
      vecs[4] = '{16'h0005, 4'b0100, 1'b1, 16'hFFFE, 16'h0005, 4'hF};
      vecs[5] = '{16'hABCD, 4'hF,    1'b0, 16'h7BDE, 16'hABCD, 4'h0};
      vecs[6] = '{16'h0000, 4'hF,    1'b1, 16'hFFFE, 16'h0000, 4'b1110};
      vecs[7] = '{16'h0300, 4'b0010, 1'b1, 16'hFBDE, 16'h0300, 4'b1101};

      rst_n = 1'b0;
      bus.value_in = 16'h0; bus.dp_in = 4'h0; bus.load = 1'b0; bus.blank_lz = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk_out("reset", 4'hF, 4'h0, 1'b0);
      chk("reset_dp", {15'h0, bus.dp_out_n}, 16'h0001);
      rst_n = 1'b1;

      // First GAP load, then the first frame.
      bus.value_in = 16'h1234; bus.load = 1'b1;
      step();
      bus.load = 1'b0;
      chk_out("first_gap", 4'hF, 4'h0, 1'b0);
      step();
      chk_out("first_boundary", 4'b1110, 4'h4, 1'b1);
      repeat (3) step();
      chk_out("d0_last", 4'b1110, 4'h4, 1'b0);
      step();
      chk_out("d0_gap", 4'hF, 4'h4, 1'b0);
      repeat (2) step();
      chk_out("d1_drive", 4'b1101, 4'h3, 1'b0);

      // Mid-frame load must not disturb the rest of this frame.
      bus.value_in = 16'hABCD; bus.load = 1'b1;
      step();
      bus.load = 1'b0;
      repeat (5) step();
      chk_out("midload_d2", 4'b1011, 4'h2, 1'b0);
      repeat (6) step();
      chk_out("midload_d3", 4'b0111, 4'h1, 1'b0);
      repeat (6) step();
      chk_out("midload_next_d0", 4'b1110, 4'hD, 1'b1);

      // Load on the boundary edge itself.
      repeat (F - 1) step();
      bus.value_in = 16'h5555; bus.load = 1'b1;
      step();
      bus.load = 1'b0;
      chk_out("boundary_load", 4'b1110, 4'h5, 1'b1);

      for (int v = 0; v < 8; v++) begin
         bus.value_in = vecs[v].value; bus.dp_in = vecs[v].dp;
         bus.blank_lz = vecs[v].blank; bus.load = 1'b1;
         step();
         bus.load = 1'b0;
         wait_frame();
         for (int d = 0; d < 4; d++) begin
            chk($sformatf("vec%0d_d%0d_en", v, d), {12'h0, bus.digit_en_n}, {12'h0, vecs[v].en[4*d +: 4]});
            chk($sformatf("vec%0d_d%0d_nib", v, d), {12'h0, bus.nibble_out}, {12'h0, vecs[v].nib[4*d +: 4]});
            chk($sformatf("vec%0d_d%0d_dp", v, d), {15'h0, bus.dp_out_n}, {15'h0, vecs[v].dpn[d]});
            if (d < 3) repeat (C + B) step();
         end
      end

      for (int i = 0; i < 480; i++) begin
         bus.load     = ($urandom % 8) == 0;
         bus.value_in = 16'($urandom);
         bus.dp_in    = 4'($urandom);
         if (($urandom % 16) == 0) bus.blank_lz = ~bus.blank_lz;
         step();
      end

      // Asynchronous reset in the middle of digit 1 DRIVE.
      bus.load = 1'b0; bus.blank_lz = 1'b0;
      bus.value_in = 16'h4321; bus.load = 1'b1;
      step();
      bus.load = 1'b0;
      wait_frame();
      repeat (7) step();
      chk_out("pre_reset_d1", 4'b1101, 4'h2, 1'b0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk_out("async_reset", 4'hF, 4'h0, 1'b0);
      chk("async_reset_dp", {15'h0, bus.dp_out_n}, 16'h0001);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step();
      chk_out("rerelease_gap", 4'hF, 4'h0, 1'b0);
      step();
      chk_out("rerelease_d0", 4'b1110, 4'h0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
